// File: rtl/msg_comm_pkg.sv
// Shared types for the message-comm transmit arbiter: FSM states, length limits, header byte format.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package msg_comm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Length field width matches the far-end 11-bit receive RAM address space.
  localparam int MSG_LEN_W   = 11;
  localparam int MSG_MAX_LEN = 2045;
  localparam int HDR_SRC_W   = 3;

  // Header byte: reserved zeros above a 3-bit source ID.
  typedef struct packed {
    logic [7-HDR_SRC_W:0] rsvd;
    logic [HDR_SRC_W-1:0] src;
  } hdr_t;

  function automatic logic [7:0] hdr_byte(input logic [HDR_SRC_W-1:0] src);
    hdr_t h;
    h.rsvd = '0;
    h.src  = src;
    return h;
  endfunction

endpackage

// File: rtl/msg_comm_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module msg_comm_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld && req[(int'(ptr) + k) % N]) begin
        vld = 1'b1;
        idx = PTR_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/msg_comm_tx_arbiter.sv
// Shares one message-comm TX link among REQ_NUM sources; frames each grant as header + payload burst.
// Latency: grant and header one cycle after the decision, payload follows back-to-back, then a GAP_CYCLES idle gap.
// Backpressure: tx_busy_i holds off a new grant (checked in idle and at gap end); no stall inside a burst.
module msg_comm_tx_arbiter
  import msg_comm_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int MAX_LEN    = MSG_MAX_LEN,
  parameter int GAP_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           req_i,
  input  logic [REQ_NUM*MSG_LEN_W-1:0] req_len_i,
  input  logic [REQ_NUM*8-1:0]         src_data_i,
  output logic [REQ_NUM-1:0]           src_rd_o,
  output logic [REQ_NUM-1:0]           gnt_o,
  output logic                         tx_data_vld_o,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_data_last_o,
  input  logic                         tx_busy_i,
  output logic                         err_len_o
);

  localparam int PTR_W = $clog2(REQ_NUM);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(REQ_NUM - 1);
  localparam logic [GAP_W-1:0]     GAP_END   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [MSG_LEN_W-1:0] MAX_LEN_V = MSG_LEN_W'(MAX_LEN);
  localparam logic [MSG_LEN_W-1:0] LEN_ONE   = MSG_LEN_W'(1);
  localparam logic [REQ_NUM-1:0]   ONE_HOT0  = REQ_NUM'(1);

  arb_state_t           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     win_idx;
  logic [MSG_LEN_W-1:0] len_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [MSG_LEN_W-1:0] pick_len;
  logic                 pick_len_ok;
  logic [PTR_W-1:0]     next_ptr;

  msg_comm_rr_pick #(
    .N     (REQ_NUM),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Length legality and pointer advance for the current pick.
  always_comb begin
    pick_len    = req_len_i[int'(pick_idx)*MSG_LEN_W +: MSG_LEN_W];
    pick_len_ok = (pick_len != '0) && (pick_len <= MAX_LEN_V);
    next_ptr    = (pick_idx == LAST_IDX) ? '0 : pick_idx + PTR_W'(1);
  end

  // Pop strobe toward the granted source for every payload-fetch cycle.
  always_comb begin
    src_rd_o = '0;
    if (state == ST_DATA) begin
      src_rd_o = ONE_HOT0 << win_idx;
    end
  end

  // Arbitration FSM, counters and registered link-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      win_idx        <= '0;
      len_cnt        <= '0;
      gap_cnt        <= '0;
      gnt_o          <= '0;
      tx_data_vld_o  <= 1'b0;
      tx_data_o      <= 8'h00;
      tx_data_last_o <= 1'b0;
      err_len_o      <= 1'b0;
    end else begin
      err_len_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld && !tx_busy_i) begin
            win_idx <= pick_idx;
            gnt_o   <= ONE_HOT0 << pick_idx;
            rr_ptr  <= next_ptr;
            gap_cnt <= '0;
            if (pick_len_ok) begin
              len_cnt       <= pick_len;
              tx_data_vld_o <= 1'b1;
              tx_data_o     <= hdr_byte(HDR_SRC_W'(pick_idx));
              state         <= ST_DATA;
            end else begin
              // Bad length: pulse grant and error, move no data, still honour the gap.
              err_len_o <= 1'b1;
              state     <= ST_GAP;
            end
          end
        end
        ST_DATA: begin
          tx_data_o     <= src_data_i[int'(win_idx)*8 +: 8];
          tx_data_vld_o <= 1'b1;
          len_cnt       <= len_cnt - LEN_ONE;
          if (len_cnt == LEN_ONE) begin
            tx_data_last_o <= 1'b1;
            state          <= ST_GAP;
          end
        end
        ST_GAP: begin
          gnt_o          <= '0;
          tx_data_vld_o  <= 1'b0;
          tx_data_last_o <= 1'b0;
          if (gap_cnt != GAP_END) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end else if (!tx_busy_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/msg_comm_tx_arbiter.md
# msg_comm_tx_arbiter

Round-robin scheduler that shares the single x4 message-comm transmit link between REQ_NUM on-board message sources. It grants one source at a time and frames that source's payload as one contiguous byte burst: a source-ID header byte, then the payload bytes. The burst goes to the link transmit engine, which appends CRC8 and serialises on MSG_CLK. The block enforces an inter-frame idle gap so that the far-end receiver's FSX falling-edge frame detection always separates frames.

## Interface
- REQ_NUM, 4: number of requesters, 2..8.
- MAX_LEN, 2045: maximum payload bytes per frame; header plus payload must fit the 11-bit receive RAM.
- GAP_CYCLES, 16: minimum idle clk cycles between frames.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  REQ_NUM  level request per source; held until the matching gnt_o rises.
- req_len_i  in  REQ_NUM*11  payload length per source, slice i = [i*11+:11]; stable while req_i[i] is high.
- src_data_i  in  REQ_NUM*8  per-source first-word-fall-through byte; the whole payload must be buffered before req_i is raised.
- src_rd_o  out  REQ_NUM  consume strobe per source; pops the current src_data_i byte.
- gnt_o  out  REQ_NUM  one-hot grant, registered.
- tx_data_vld_o  out  1  byte valid toward the link transmit engine.
- tx_data_o  out  8  header or payload byte.
- tx_data_last_o  out  1  marks the final byte of a frame.
- tx_busy_i  in  1  link engine is still serialising the previous frame or its CRC.
- err_len_o  out  1  one-cycle pulse when a granted length is illegal.

## Operation
- States: ST_IDLE, ST_DATA, ST_GAP.
- ST_IDLE
  - Leaves IDLE when |req_i and !tx_busy_i. The winner is the first set req_i found at or after rr_ptr, wrapping modulo REQ_NUM.
  - Legal length (1..MAX_LEN):
    - gnt_o <= onehot(winner); len_cnt <= req_len_i[winner].
    - tx_data_vld_o <= 1; tx_data_o <= {5'd0, winner[2:0]}.
    - Next state: ST_DATA.
  - Illegal length (0 or > MAX_LEN):
    - gnt_o <= onehot(winner) for one cycle; err_len_o <= 1.
    - No data moves. Next state: ST_GAP.
  - The requester must drop req_i on seeing gnt_o.
  - In both cases rr_ptr <= (winner+1) mod REQ_NUM.
- ST_DATA
  - src_rd_o[winner] = 1 combinationally, every cycle.
  - tx_data_o <= src_data_i[winner]; tx_data_vld_o <= 1; len_cnt decrements.
  - When len_cnt == 1: tx_data_last_o <= 1, next state ST_GAP.
- ST_GAP
  - gnt_o <= 0; tx_data_vld_o <= 0; tx_data_last_o <= 0.
  - gap_cnt counts GAP_CYCLES.
  - Returns to ST_IDLE only when gap_cnt has expired and !tx_busy_i.
- Requests arriving or dropping during ST_DATA or ST_GAP do not affect the current frame. A req_i drop by the granted source mid-frame is ignored; all len bytes are still read.
- Width rules:
  - len_cnt is 11 bits and is compared against MAX_LEN at 11 bits.
  - gap_cnt is $clog2(GAP_CYCLES+1) bits.
  - rr_ptr is $clog2(REQ_NUM) bits and wraps at REQ_NUM-1 -> 0.

## Timing
- Reset (asynchronous, mid-frame included):
  - State ST_IDLE, rr_ptr 0, counters 0.
  - gnt_o, src_rd_o, tx_data_vld_o, tx_data_last_o, err_len_o all 0; tx_data_o 8'h00.
  - A frame in progress is abandoned without tx_data_last_o.
- Arbitration decision in cycle c (IDLE, request present, not busy):
  - gnt_o and the header byte appear at c+1.
  - src_rd_o is high for c+1..c+len.
  - Payload bytes appear at c+2..c+1+len; tx_data_last_o is high at c+1+len.
  - gnt_o falls at c+2+len.
- tx_data_vld_o is contiguous for len+1 cycles with no bubbles.
- Next-grant spacing is at least GAP_CYCLES cycles after the last byte, extended while tx_busy_i is high.
- Illegal length: gnt_o and err_len_o are high for exactly one cycle (c+1). The gap still applies.
- tx_busy_i is sampled only in ST_IDLE and at the end of ST_GAP.

## Structure
- Package msg_comm_pkg:
  - State encodings.
  - MSG_LEN_W = 11, MSG_MAX_LEN, header byte format.
- Sub-module msg_comm_rr_pick:
  - Combinational round-robin pick.
  - Inputs: req vector and pointer. Outputs: winner index and any-valid.
  - Instantiated once.
- The FSM, counters and output registers live in the top module.

## Test plan
- Single request, source 2, len 3, bytes A1 A2 A3: cycle c+1 shows gnt_o = 0100 and header 02; cycles c+2..c+4 show A1 A2 A3 with last on A3; src_rd_o[2] is high for exactly 3 cycles.
- All four sources request continuously, rr_ptr = 0: grant order is 0,1,2,3,0; consecutive frames are separated by ≥16 idle cycles.
- tx_busy_i held high for 40 cycles after a frame: no grant until the cycle after tx_busy_i falls.
- Length 0 on source 1, then length 2046 on source 3: each produces a one-cycle gnt_o plus err_len_o and no tx_data_vld_o; rr_ptr advances to 2, then to 0.
- rst_n asserted at payload byte 5 of a 10-byte frame: all outputs go to 0 immediately; after release, a new request gets a header from rr_ptr = 0.
- Max frame, len 2045: exactly 2046 valid cycles; the last byte carries tx_data_last_o; len_cnt shows no wrap.
